fp_pack: RTL

Multi-cycle IEEE 754 single-precision result packer: accepts an unpacked sign / biased exponent / extended significand plus special-value flags from the FPU datapath, normalizes iteratively (one bit per cycle), rounds per RISC-V rounding mode, and emits the packed 32-bit float with RISC-V fflags. It is the encode-side counterpart of the FPU classify/unpack path, sitting between the FP arithmetic units and the FP register-file writeback.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_round.sv | 28 ++
 rtl/fp_pack.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 result packer.
package fp_pkg;

  // RISC-V rounding modes; encodings 101-111 are handled as RNE by the rounder.
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  // Bit positions inside fflags {NV,DZ,OF,UF,NX}.
  localparam int FFLAG_NX = 0;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_NV = 4;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_MAXF = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_round.sv
// Rounding decision for a 24-bit mantissa with guard and sticky bits.
module fp_round
  import fp_pkg::*;
(
  input  logic [23:0] mant,
  input  logic        g,
  input  logic        s,
  input  logic        sign,
  input  logic [2:0]  rm,
  output logic        inc,
  output logic        nx,
  output logic        cout
);

  // Increment decision per rounding mode; cout flags a mantissa wrap to 2^24.
  always_comb begin
    nx = g | s;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & nx;
      RM_RUP:  inc = ~sign & nx;
      RM_RMM:  inc = g;
      default: inc = g & (s | mant[0]);
    endcase
    cout = inc & (&mant);
  end

endmodule

// File: rtl/fp_pack.sv
// Multi-cycle binary32 packer: iterative normalize, RISC-V rounding, fflags.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | o_ready high; accept operand, specials go straight to DONE
// ST_NORM  | one shift per cycle until hidden bit set or exponent hits 1
// ST_ROUND | round, detect overflow, load registered result and flags
// ST_DONE  | o_valid high, outputs held until i_ready
module fp_pack
  import fp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_sign,
  input  logic [9:0]  i_exp,
  input  logic [26:0] i_sig,
  input  logic        i_is_nan,
  input  logic        i_is_inf,
  input  logic        i_is_zero,
  input  logic [2:0]  i_rm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_fflags
);

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  // One extra bit so the post-round exponent increment cannot wrap.
  logic signed [10:0] exp_q, exp_d;
  logic [26:0]        sig_q, sig_d;
  logic [2:0]         rm_q, rm_d;
  logic               valid_q, valid_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         fflags_q, fflags_d;

  logic               rnd_inc, rnd_nx, rnd_cout;
  logic [23:0]        mant_rnd;
  logic signed [10:0] exp_rnd;
  logic [7:0]         field;
  logic               ovf, hold_max;
  logic [31:0]        rnd_result;
  logic [4:0]         rnd_flags;

  fp_round u_round (
    .mant (sig_q[26:3]),
    .g    (sig_q[2]),
    .s    (|sig_q[1:0]),
    .sign (sign_q),
    .rm   (rm_q),
    .inc  (rnd_inc),
    .nx   (rnd_nx),
    .cout (rnd_cout)
  );

  // Rounded value, exponent field and overflow saturation target.
  always_comb begin
    mant_rnd = rnd_cout ? 24'h80_0000 : sig_q[26:3] + {23'b0, rnd_inc};
    exp_rnd  = exp_q + (rnd_cout ? 11'sd1 : 11'sd0);
    // A subnormal that rounds up into the hidden bit naturally encodes exp 1.
    field    = mant_rnd[23] ? exp_rnd[7:0] : 8'd0;
    ovf      = mant_rnd[23] && (exp_rnd >= 11'sd255);
    hold_max = (rm_q == RM_RTZ) || ((rm_q == RM_RDN) && !sign_q) ||
               ((rm_q == RM_RUP) && sign_q);
    if (ovf) begin
      rnd_result = {sign_q, hold_max ? FP_MAXF[30:0] : FP_INF[30:0]};
    end else begin
      rnd_result = {sign_q, field, mant_rnd[22:0]};
    end
    rnd_flags                = '0;
    rnd_flags[FFLAG_OF]      = ovf;
    rnd_flags[FFLAG_UF]      = ~sig_q[26] & rnd_nx;
    rnd_flags[FFLAG_NX]      = rnd_nx | ovf;
  end

  // Next-state and datapath update for the packer FSM.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    sig_d    = sig_q;
    rm_d     = rm_q;
    valid_d  = valid_q;
    result_d = result_q;
    fflags_d = fflags_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          sign_d = i_sign;
          exp_d  = {i_exp[9], i_exp};
          sig_d  = i_sig;
          rm_d   = i_rm;
          if (i_is_nan) begin
            result_d = FP_QNAN;
            fflags_d = '0;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else if (i_is_inf) begin
            result_d = {i_sign, FP_INF[30:0]};
            fflags_d = '0;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else if (i_is_zero || (i_sig == 27'd0)) begin
            result_d = {i_sign, 31'b0};
            fflags_d = '0;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (exp_q < -11'sd26) begin
          // Everything lands below the sticky position; keep only nonzero-ness.
          sig_d = {26'b0, |sig_q};
          exp_d = 11'sd1;
        end else if (exp_q < 11'sd1) begin
          sig_d = {1'b0, sig_q[26:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + 11'sd1;
        end else if (!sig_q[26] && (exp_q > 11'sd1)) begin
          sig_d = {sig_q[25:0], 1'b0};
          exp_d = exp_q - 11'sd1;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        result_d = rnd_result;
        fflags_d = rnd_flags;
        valid_d  = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      rm_q     <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      sig_q    <= sig_d;
      rm_q     <= rm_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      fflags_q <= fflags_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_fflags = fflags_q;

endmodule
